led_scan_receiver: RTL and testbench

Receiving end of the seven-segment display interface driven by the BCD counter's LED decoder and digit multiplexer. The block samples a time-multiplexed segment bus (7 segment lines plus one-hot digit enables) and debounces each digit's dwell. It maps each segment pattern back to BCD for either LED polarity, then assembles a full multi-digit frame with a one-cycle valid strobe and per-digit error flags. It serves as the on-chip loopback checker and bench monitor for the display path.

---
 rtl/led_scan_receiver_if.sv | 28 ++
 rtl/led_scan_receiver.sv | 126 ++++++++++++
 tb/tb_led_scan_receiver.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/led_scan_receiver_if.sv
// Segment-bus / frame-output bundle for led_scan_receiver.
//   master (display driver / bench): drives digit, anode_en, LED_type_ctl;
//                                    observes frame_bcd, frame_valid,
//                                    frame_err, digit_err_mask.
//   slave  (led_scan_receiver):      the reverse direction.
// digit is indexed [0:6] so that bit 0 = segment a ... bit 6 = segment g,
// which makes a 7'bxxxxxxx literal read left-to-right as a..g.
interface led_scan_receiver_if #(
    parameter int NUM_DIGITS = 4
);
    logic [0:6]              digit;
    logic [NUM_DIGITS-1:0]   anode_en;
    logic                    LED_type_ctl;
    logic [4*NUM_DIGITS-1:0] frame_bcd;
    logic                    frame_valid;
    logic                    frame_err;
    logic [NUM_DIGITS-1:0]   digit_err_mask;

    modport master (
        output digit, anode_en, LED_type_ctl,
        input  frame_bcd, frame_valid, frame_err, digit_err_mask
    );

    modport slave (
        input  digit, anode_en, LED_type_ctl,
        output frame_bcd, frame_valid, frame_err, digit_err_mask
    );
endinterface

// File: rtl/led_scan_receiver.sv
// Seven-segment scan receiver: samples a multiplexed segment bus, debounces
// each digit dwell, decodes the segment pattern back to BCD (either LED
// polarity) and assembles a NUM_DIGITS frame with a one-cycle valid strobe
// and per-digit error flags.
// Ports:
//   clk   - system clock, rising edge
//   reset - synchronous, active-high
//   bus   - led_scan_receiver_if.slave (segment inputs, frame outputs)
module led_scan_receiver #(
    parameter int NUM_DIGITS    = 4,
    parameter int STABLE_CYCLES = 4
) (
    input  logic               clk,
    input  logic               reset,
    led_scan_receiver_if.slave bus
);
    localparam int CW = $clog2(STABLE_CYCLES + 1);
    localparam int KW = 7 + NUM_DIGITS + 1;

    logic [KW-1:0]           r_s;
    logic [CW-1:0]           r_cnt;
    logic [4*NUM_DIGITS-1:0] r_slot_bcd;
    logic [NUM_DIGITS-1:0]   r_slot_err;
    logic [NUM_DIGITS-1:0]   r_mask;
    logic [4*NUM_DIGITS-1:0] r_frame_bcd;
    logic                    r_frame_valid;
    logic                    r_frame_err;
    logic [NUM_DIGITS-1:0]   r_digit_err_mask;

    logic [KW-1:0]           w_key;
    logic                    w_same;
    logic                    w_accept;
    logic                    w_complete;
    logic [0:6]              w_norm;
    logic [3:0]              w_dec;
    logic                    w_dec_err;
    logic [4*NUM_DIGITS-1:0] w_bcd_next;
    logic [NUM_DIGITS-1:0]   w_err_next;
    logic [NUM_DIGITS-1:0]   w_mask_next;

    assign w_key  = {bus.digit, bus.anode_en, bus.LED_type_ctl};
    assign w_same = (w_key == r_s);
    // Accept fires only on the edge the counter passes STABLE_CYCLES-1, so a
    // saturated counter never re-accepts within the same dwell.
    assign w_accept = w_same && (r_cnt == CW'(STABLE_CYCLES - 1)) && $onehot(bus.anode_en);

    // Fold active-high input into the active-low table by inversion.
    always_comb begin
        w_norm    = bus.LED_type_ctl ? bus.digit : ~bus.digit;
        w_dec     = 4'hF;
        w_dec_err = 1'b0;
        case (w_norm)
            7'b0000001: w_dec = 4'd0;
            7'b1001111: w_dec = 4'd1;
            7'b0010010: w_dec = 4'd2;
            7'b0000110: w_dec = 4'd3;
            7'b1001100: w_dec = 4'd4;
            7'b0100100: w_dec = 4'd5;
            7'b0100000: w_dec = 4'd6;
            7'b0001111: w_dec = 4'd7;
            7'b0000000: w_dec = 4'd8;
            7'b0000100: w_dec = 4'd9;
            default: begin
                w_dec     = 4'hF;
                w_dec_err = 1'b1;
            end
        endcase
    end

    // Slot state as it will be after this edge's accept, so a completing
    // accept can publish the frame including its own digit.
    always_comb begin
        w_bcd_next  = r_slot_bcd;
        w_err_next  = r_slot_err;
        w_mask_next = r_mask;
        if (w_accept) begin
            for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
                if (bus.anode_en[i]) begin
                    w_bcd_next[4*i +: 4] = w_dec;
                    w_err_next[i]        = w_dec_err;
                    w_mask_next[i]       = 1'b1;
                end
            end
        end
    end

    assign w_complete = w_accept && (&w_mask_next);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_s              <= '0;
            r_cnt            <= '0;
            r_slot_bcd       <= '0;
            r_slot_err       <= '0;
            r_mask           <= '0;
            r_frame_bcd      <= '0;
            r_frame_valid    <= 1'b0;
            r_frame_err      <= 1'b0;
            r_digit_err_mask <= '0;
        end else begin
            r_s           <= w_key;
            r_frame_valid <= 1'b0;
            if (!w_same) begin
                r_cnt <= CW'(1);
            end else if (r_cnt != CW'(STABLE_CYCLES)) begin
                r_cnt <= r_cnt + CW'(1);
            end
            if (w_accept) begin
                r_slot_bcd <= w_bcd_next;
                r_slot_err <= w_err_next;
                r_mask     <= w_complete ? '0 : w_mask_next;
            end
            if (w_complete) begin
                r_frame_bcd      <= w_bcd_next;
                r_digit_err_mask <= w_err_next;
                r_frame_err      <= |w_err_next;
                r_frame_valid    <= 1'b1;
            end
        end
    end

    assign bus.frame_bcd      = r_frame_bcd;
    assign bus.frame_valid    = r_frame_valid;
    assign bus.frame_err      = r_frame_err;
    assign bus.digit_err_mask = r_digit_err_mask;
endmodule

// File: tb/tb_led_scan_receiver.sv
// Directed bench for led_scan_receiver (NUM_DIGITS=4, STABLE_CYCLES=4).
module tb_led_scan_receiver;
    logic clk;
    logic reset;
    int   tests;
    int   failed;
    int   pulses;

    led_scan_receiver_if #(.NUM_DIGITS(4)) bus ();

    led_scan_receiver #(.NUM_DIGITS(4), .STABLE_CYCLES(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count strobes away from the active edge.
    always @(negedge clk) if (bus.frame_valid === 1'b1) pulses++;

    // Active-low segment patterns, a..g left to right.
    function automatic logic [6:0] seg_al(input int d);
        case (d)
            0: return 7'b0000001;
            1: return 7'b1001111;
            2: return 7'b0010010;
            3: return 7'b0000110;
            4: return 7'b1001100;
            5: return 7'b0100100;
            6: return 7'b0100000;
            7: return 7'b0001111;
            8: return 7'b0000000;
            9: return 7'b0000100;
            default: return 7'b1111111;
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Drive a key then let n rising edges pass; returns #1 after the last edge.
    task automatic dwell(input logic [6:0] pat, input logic [3:0] an, input logic typ, input int n);
        bus.digit        = pat;
        bus.anode_en     = an;
        bus.LED_type_ctl = typ;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        dwell(7'b1111111, 4'b0000, 1'b1, n);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        dwell(7'b1010101, 4'b0110, 1'b0, 2);
        reset = 1'b0;
    endtask

    int p0;

    initial begin
        tests  = 0;
        failed = 0;
        pulses = 0;
        reset  = 1'b0;
        bus.digit        = '0;
        bus.anode_en     = '0;
        bus.LED_type_ctl = 1'b0;
        @(posedge clk); #1;

        // Reset state
        do_reset();
        check("rst_bcd",   32'(bus.frame_bcd),      32'h0);
        check("rst_valid", 32'(bus.frame_valid),    32'h0);
        check("rst_err",   32'(bus.frame_err),      32'h0);
        check("rst_mask",  32'(bus.digit_err_mask), 32'h0);
        p0 = pulses;
        idle(20);
        check("rst_nostrobe", 32'(pulses - p0), 32'd0);

        // Active-low scan 1,2,3,4
        p0 = pulses;
        dwell(seg_al(1), 4'b0001, 1'b1, 4);
        dwell(seg_al(2), 4'b0010, 1'b1, 4);
        dwell(seg_al(3), 4'b0100, 1'b1, 4);
        dwell(seg_al(4), 4'b1000, 1'b1, 4);
        check("al_valid", 32'(bus.frame_valid), 32'h1);
        check("al_bcd",   32'(bus.frame_bcd),   32'h4321);
        check("al_err",   32'(bus.frame_err),   32'h0);
        idle(1);
        check("al_valid_drop", 32'(bus.frame_valid), 32'h0);
        check("al_bcd_hold",   32'(bus.frame_bcd),   32'h4321);
        idle(3);
        check("al_one_pulse", 32'(pulses - p0), 32'd1);

        // Active-high scan 0,8,9,1
        p0 = pulses;
        dwell(7'b1111110, 4'b0001, 1'b0, 4);
        dwell(7'b1111111, 4'b0010, 1'b0, 4);
        dwell(7'b1111011, 4'b0100, 1'b0, 4);
        dwell(7'b0110000, 4'b1000, 1'b0, 4);
        check("ah_valid", 32'(bus.frame_valid),    32'h1);
        check("ah_bcd",   32'(bus.frame_bcd),      32'h1980);
        check("ah_mask",  32'(bus.digit_err_mask), 32'h0);
        idle(3);
        check("ah_one_pulse", 32'(pulses - p0), 32'd1);

        // Glitch rejection: 3-cycle slot-0 dwell must not capture
        do_reset();
        p0 = pulses;
        dwell(seg_al(7), 4'b0001, 1'b1, 3);
        dwell(seg_al(7), 4'b0000, 1'b1, 1);
        dwell(seg_al(1), 4'b0010, 1'b1, 4);
        dwell(seg_al(2), 4'b0100, 1'b1, 4);
        dwell(seg_al(3), 4'b1000, 1'b1, 4);
        idle(3);
        check("gl_short_dropped", 32'(pulses - p0), 32'd0);
        dwell(seg_al(6), 4'b0001, 1'b1, 10);
        check("gl_bcd",      32'(bus.frame_bcd), 32'h3216);
        check("gl_one_pulse", 32'(pulses - p0),  32'd1);
        // A re-accept during the long dwell would let these three complete.
        dwell(seg_al(4), 4'b0010, 1'b1, 4);
        dwell(seg_al(4), 4'b0100, 1'b1, 4);
        dwell(seg_al(4), 4'b1000, 1'b1, 4);
        idle(3);
        check("gl_no_reaccept", 32'(pulses - p0), 32'd1);

        // Invalid pattern on slot 2
        do_reset();
        p0 = pulses;
        dwell(seg_al(5),  4'b0001, 1'b1, 4);
        dwell(seg_al(5),  4'b0010, 1'b1, 4);
        dwell(7'b1111111, 4'b0100, 1'b1, 4);
        dwell(seg_al(5),  4'b1000, 1'b1, 4);
        check("inv_valid", 32'(bus.frame_valid),    32'h1);
        check("inv_bcd",   32'(bus.frame_bcd),      32'h5F55);
        check("inv_mask",  32'(bus.digit_err_mask), 32'h4);
        check("inv_err",   32'(bus.frame_err),      32'h1);

        // Illegal multi-hot enable never captures
        do_reset();
        p0 = pulses;
        dwell(seg_al(8), 4'b0011, 1'b1, 10);
        dwell(seg_al(2), 4'b0100, 1'b1, 4);
        dwell(seg_al(3), 4'b1000, 1'b1, 4);
        idle(3);
        check("mh_no_accept", 32'(pulses - p0), 32'd0);

        // Reset mid-frame discards the partial frame
        do_reset();
        p0 = pulses;
        dwell(seg_al(1), 4'b0001, 1'b1, 4);
        dwell(seg_al(1), 4'b0010, 1'b1, 4);
        dwell(seg_al(1), 4'b0100, 1'b1, 4);
        do_reset();
        dwell(seg_al(9), 4'b1000, 1'b1, 4);
        idle(3);
        check("rst_partial_dropped", 32'(pulses - p0), 32'd0);
        dwell(seg_al(7), 4'b0001, 1'b1, 4);
        dwell(seg_al(8), 4'b0010, 1'b1, 4);
        dwell(seg_al(0), 4'b0100, 1'b1, 4);
        check("rst_refill_valid", 32'(bus.frame_valid), 32'h1);
        check("rst_refill_bcd",   32'(bus.frame_bcd),   32'h9087);
        idle(3);
        check("rst_refill_pulse", 32'(pulses - p0), 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
